fir_coef_loader: RTL

Writer side of the FIR tap weight interface: accepts coefficients one word at a time over a valid/ready stream and drives the flat weight bus feeding the tap chain's iv_weight inputs.
- Double-buffered: a shadow bank fills during loading; the active bank driving the taps updates atomically in one cycle.
- The filter never sees a partially loaded coefficient set.
- Sits between the host/config path and the FIR tap array.

---
 rtl/fir_coef_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader: a valid/ready stream fills a shadow bank, and a commit copies it to the tap weights in one cycle.
// Optional macro FIR_COEF_SYM_EN adds i_sym to load symmetric sets from ceil(NUM_TAPS/2) words.
//   state    | meaning
//   S_IDLE   | waiting for i_start; active bank stable
//   S_LOAD   | accepting coefficient words into the shadow bank
//   S_COMMIT | shadow -> active copy at the next edge, o_done follows
module fir_coef_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
`ifdef FIR_COEF_SYM_EN
  input  logic                           i_sym,
`endif
  input  logic                           i_coef_valid,
  input  logic [DATA_WIDTH-1:0]          iv_coef,
  output logic                           o_coef_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] LAST_SYM  = IDX_W'((NUM_TAPS + 1) / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shadow_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_TAPS];
  logic [DATA_WIDTH-1:0] active_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] active_d [NUM_TAPS];
  logic                  done_q, done_d;
  logic                  load_sym;
  logic                  xfer;
  logic                  last_word;
  logic [IDX_W-1:0]      last_idx;
  logic [IDX_W-1:0]      mir_idx;

`ifdef FIR_COEF_SYM_EN
  logic sym_q, sym_d;

  always_comb begin
    sym_d = sym_q;
    if (state_q == S_IDLE) sym_d = i_sym;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sym_q <= 1'b0;
    else       sym_q <= sym_d;
  end

  assign load_sym = sym_q;
`else
  assign load_sym = 1'b0;
`endif

  assign xfer      = i_coef_valid && (state_q == S_LOAD);
  assign last_idx  = load_sym ? LAST_SYM : LAST_FULL;
  assign last_word = (idx_q == last_idx);
  assign mir_idx   = LAST_FULL - idx_q;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic; abort takes priority over start and over the final word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_start && !i_abort) state_d = S_LOAD;
      S_LOAD: begin
        if (i_abort)                state_d = S_IDLE;
        else if (xfer && last_word) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (state_q == S_IDLE && i_start && !i_abort) idx_d = '0;
    if (xfer && !i_abort) begin
      shadow_d[idx_q] = iv_coef;
      if (load_sym) shadow_d[mir_idx] = iv_coef;
      if (!last_word) idx_d = idx_q + IDX_W'(1);
    end
    if (state_q == S_COMMIT) begin
      active_d = shadow_q;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // outputs depend on registered state only
  always_comb begin
    o_coef_ready = (state_q == S_LOAD);
    o_busy       = (state_q == S_LOAD) || (state_q == S_COMMIT);
    o_done       = done_q;
    ov_weights   = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      ov_weights[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
  end

endmodule
